// File: rtl/ma_channel_scheduler.sv
// ---------------------------------------------------------------------------
// ma_channel_scheduler
//
// Purpose:
//   Shares one 8-tap moving-average datapath between NCH sample streams.
//   Every channel keeps its own 7-sample history. At most one channel is
//   granted per cycle. The granted sample is averaged with that channel's
//   history. The result lands in a single registered output, tagged with
//   the channel number and held under valid/ready backpressure.
//
// Configuration macro:
//   MA_SCHED_STRICT_PRIO_EN - when defined, the lowest-numbered valid
//   channel always wins. When undefined (default), arbitration is
//   round-robin starting after the last granted channel.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset
//   in_valid   - per-channel sample valid [NCH]
//   in_data    - per-channel signed samples, channel c at [c*DW +: DW]
//   in_ready   - per-channel grant, one-hot or zero
//   out_valid  - an average is held in the output register
//   out_ready  - consumer accepts the output this cycle
//   out_data   - signed 8-sample average (floor of sum/8)
//   out_ch     - channel that produced out_data
// ---------------------------------------------------------------------------
module ma_channel_scheduler #(
  parameter int NCH = 4,
  parameter int DW  = 16,
  localparam int CW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*DW-1:0] in_data,
  output logic [NCH-1:0]    in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [CW-1:0]     out_ch
);

  // Entry 0 holds the newest past sample (hist[1]); entry 6 the oldest (hist[7]).
  logic [DW-1:0]        r_hist [NCH][7];
  logic                 r_outValid;
  logic [DW-1:0]        r_outData;
  logic [CW-1:0]        r_outCh;
`ifndef MA_SCHED_STRICT_PRIO_EN
  logic [CW-1:0]        r_last;
  logic [CW-1:0]        w_cand;
`endif

  logic                 w_free;
  logic                 w_found;
  logic [CW-1:0]        w_sel;
  logic [NCH-1:0]       w_grant;
  logic [DW-1:0]        w_x;
  logic signed [DW+2:0] w_sum;
  logic [DW-1:0]        w_avg;

  assign w_free    = !r_outValid || out_ready;
  assign in_ready  = w_grant;
  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_ch    = r_outCh;

  // Arbiter: pick at most one requesting channel when the output slot is free.
  // Nothing is granted while reset is held. Because NCH is a power of two,
  // truncating the candidate index to CW bits gives the modulo wrap for free.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_sel   = '0;
`ifndef MA_SCHED_STRICT_PRIO_EN
    w_cand  = '0;
`endif
    if (w_free && !reset) begin
`ifdef MA_SCHED_STRICT_PRIO_EN
      for (int i = 0; i < NCH; i++) begin
        if (!w_found && in_valid[i]) begin
          w_found = 1'b1;
          w_sel   = CW'(i);
        end
      end
`else
      for (int i = 1; i <= NCH; i++) begin
        w_cand = r_last + CW'(i);
        if (!w_found && in_valid[w_cand]) begin
          w_found = 1'b1;
          w_sel   = w_cand;
        end
      end
`endif
      if (w_found) begin
        w_grant[w_sel] = 1'b1;
      end
    end
  end

  // Datapath: sum the granted sample with its seven predecessors in DW+3 bits,
  // which cannot overflow. An arithmetic shift by 3 then rounds toward -inf.
  always_comb begin
    w_x   = in_data[w_sel*DW +: DW];
    w_sum = {{3{w_x[DW-1]}}, w_x};
    for (int k = 0; k < 7; k++) begin
      w_sum = w_sum + {{3{r_hist[w_sel][k][DW-1]}}, r_hist[w_sel][k]};
    end
    w_avg = DW'(w_sum >>> 3);
  end

  // State update: an accept loads the output register and shifts only the
  // granted channel's history. A drain without an accept just clears the valid.
  // While backpressured nothing is granted, so everything stays frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < 7; k++) begin
          r_hist[c][k] <= '0;
        end
      end
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outCh    <= '0;
`ifndef MA_SCHED_STRICT_PRIO_EN
      r_last     <= CW'(NCH - 1);
`endif
    end else if (w_found) begin
      for (int k = 6; k > 0; k--) begin
        r_hist[w_sel][k] <= r_hist[w_sel][k-1];
      end
      r_hist[w_sel][0] <= w_x;
      r_outValid       <= 1'b1;
      r_outData        <= w_avg;
      r_outCh          <= w_sel;
`ifndef MA_SCHED_STRICT_PRIO_EN
      r_last           <= w_sel;
`endif
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ma_channel_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ma_channel_scheduler
//
// Purpose:
//   Scoreboard bench for ma_channel_scheduler. The driver keeps a reference
//   model of the block. Each channel's model is the full list of its
//   accepted samples, together with the arbitration pointer and the output
//   slot state. For every grant the model predicts, the driver pushes the
//   expected {average, channel} pair. A separate monitor compares whatever
//   the DUT presents against the head of that queue.
// ---------------------------------------------------------------------------
module tb_ma_channel_scheduler;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int CW  = $clog2(NCH);

  typedef struct {
    int data;
    int ch;
  } expT;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_ch;

  expT scoreboard[$];
  int  mHist[NCH][$];
  int  mLast;
  bit  mOutValid;
  int  vectors     = 0;
  int  miscompares = 0;

  ma_channel_scheduler #(.NCH(NCH), .DW(DW)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_ch(out_ch)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  function automatic int floorDiv8(input int s);
    floorDiv8 = (s >= 0) ? (s / 8) : -((-s + 7) / 8);
  endfunction

  function automatic logic [NCH*DW-1:0] fill(input int value);
    logic [NCH*DW-1:0] d;
    for (int c = 0; c < NCH; c++) d[c*DW +: DW] = DW'(value);
    fill = d;
  endfunction

  task automatic modelReset();
    for (int c = 0; c < NCH; c++) mHist[c].delete();
    mLast     = NCH - 1;
    mOutValid = 1'b0;
    scoreboard.delete();
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Drives one cycle of inputs. The reference model then decides which
  // channel should be granted and checks in_ready. It predicts the average
  // as floor(sum of the last 8 samples / 8), with missing history counting
  // as zero.
  task automatic applyStimulus(input logic [NCH-1:0] v, input logic [NCH*DW-1:0] d, input logic rdy);
    logic [NCH-1:0]        expGrant;
    logic signed [DW-1:0]  x;
    int                    sel;
    int                    sum;
    int                    n;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    expGrant  = '0;
    sel       = -1;
    if (!mOutValid || rdy) begin
`ifdef MA_SCHED_STRICT_PRIO_EN
      for (int i = 0; i < NCH; i++) if (sel < 0 && v[i]) sel = i;
`else
      for (int i = 1; i <= NCH; i++) begin
        if (sel < 0 && v[(mLast + i) % NCH]) sel = (mLast + i) % NCH;
      end
`endif
    end
    if (sel >= 0) expGrant[sel] = 1'b1;
    #1;
    checkOutput("in_ready", int'(in_ready), int'(expGrant));
    if (sel >= 0) begin
      x = d[sel*DW +: DW];
      mHist[sel].push_back(int'(x));
      n   = mHist[sel].size();
      sum = 0;
      for (int k = n - 1; k >= 0 && k >= n - 8; k--) sum += mHist[sel][k];
      scoreboard.push_back('{floorDiv8(sum), sel});
      mLast     = sel;
      mOutValid = 1'b1;
    end else if (rdy) begin
      mOutValid = 1'b0;
    end
  endtask

  task automatic resetDut();
    in_valid = '0;
    reset    = 1'b1;
    modelReset();
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Reset asserted mid-cycle must clear the output before any clock edge.
  task automatic midCycleReset();
    @(posedge clk);
    #3;
    checkOutput("pre_reset_out_valid", int'(out_valid), 1);
    reset = 1'b1;
    #1;
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_out_data", int'(out_data), 0);
    checkOutput("reset_out_ch", int'(out_ch), 0);
    checkOutput("reset_in_ready", int'(in_ready), 0);
    modelReset();
    in_valid = '0;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Monitor: compare any presented output with the scoreboard head, and pop
  // the head once the consumer accepts it. Under backpressure the same entry
  // is compared every cycle, which also confirms the output is held stable.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (scoreboard.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_output at %0t: got data %0d ch %0d, expected none",
                 $time, $signed(out_data), out_ch);
      end else begin
        checkOutput("out_data", int'($signed(out_data)), scoreboard[0].data);
        checkOutput("out_ch", int'(out_ch), scoreboard[0].ch);
        if (out_ready) void'(scoreboard.pop_front());
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;
    modelReset();
    #2;
    checkOutput("init_out_valid", int'(out_valid), 0);
    checkOutput("init_out_data", int'(out_data), 0);
    checkOutput("init_out_ch", int'(out_ch), 0);
    checkOutput("init_in_ready", int'(in_ready), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    $display("[TB] single-channel step on ch0");
    for (int i = 0; i < 8; i++) applyStimulus(4'b0001, fill(800), 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus('0, '0, 1'b1);

    $display("[TB] mid-cycle reset with output held");
    applyStimulus(4'b0001, fill(800), 1'b0);
    midCycleReset();
    applyStimulus(4'b0001, fill(800), 1'b1);
    applyStimulus('0, '0, 1'b1);

    $display("[TB] negative rounding on ch1");
    applyStimulus(4'b0010, fill(-1), 1'b1);
    for (int i = 0; i < 8; i++) applyStimulus(4'b0010, fill(0), 1'b1);
    applyStimulus('0, '0, 1'b1);

    $display("[TB] round-robin fairness");
    resetDut();
    for (int i = 0; i < 8; i++) applyStimulus(4'b1111, fill(100 * i - 350), 1'b1);

    $display("[TB] backpressure");
    for (int i = 0; i < 3; i++) applyStimulus(4'b1111, fill(77), 1'b0);
    applyStimulus(4'b1111, fill(-9), 1'b1);
    applyStimulus('0, '0, 1'b1);

`ifdef MA_SCHED_STRICT_PRIO_EN
    $display("[TB] strict priority");
    for (int i = 0; i < 4; i++) applyStimulus(4'b0101, fill(40 * i), 1'b1);
    applyStimulus(4'b0100, fill(5), 1'b1);
    applyStimulus('0, '0, 1'b1);
`endif

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      logic [NCH*DW-1:0] d;
      for (int c = 0; c < NCH; c++) d[c*DW +: DW] = DW'($urandom);
      applyStimulus(NCH'($urandom), d, ($urandom_range(0, 9) < 7));
    end

    for (int i = 0; i < 3; i++) applyStimulus('0, '0, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", scoreboard.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ma_channel_scheduler.md
# ma_channel_scheduler

Time-multiplexes one 8-tap moving-average datapath across `NCH` independent sample streams. Each channel keeps its own 7-sample history. An arbiter grants at most one channel per cycle. The block computes that channel's 8-sample average and presents it on a single registered output, tagged with the channel number and held under valid/ready backpressure. It sits between the per-channel ADC/sample front-ends and the downstream consumer that previously needed one filter instance per channel.

## Interface
Parameters:
- `NCH`, 4: number of channels; power of two, 2..16.
- `DW`, 16: sample width, signed.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, NCH: per-channel sample valid.
- `in_data`, input, NCH*DW: per-channel signed samples; channel c occupies bits [c*DW +: DW].
- `in_ready`, output, NCH: per-channel grant; one-hot or zero.
- `out_valid`, output, 1: an average is held in the output register.
- `out_ready`, input, 1: consumer accepts the output this cycle.
- `out_data`, output, DW: signed average.
- `out_ch`, output, $clog2(NCH): channel that produced `out_data`.

## Operation
- State:
  - Per-channel history `hist[c][1..7]`, DW bits each.
  - Output register: `out_valid`, `out_data`, `out_ch`.
  - Round-robin pointer `last`.
- Slot free: `free = !out_valid || out_ready`.
- Grant, combinational:
  - If `free` is 0, `in_ready` is 0.
  - Otherwise, search channels `last+1, last+2, …` modulo NCH. The first channel with `in_valid` set gets its `in_ready` bit. All other bits are 0.
- Accept: `in_valid[c] && in_ready[c]`. On an accept edge:
  - `sum = x + hist[c][1] + … + hist[c][7]`, sign-extended to DW+3 bits. No overflow is possible.
  - `out_data <= sum[DW+2:3]`. This is an arithmetic shift, rounding toward −∞.
  - `out_ch <= c`, `out_valid <= 1`.
  - `hist[c][k] <= hist[c][k-1]` for k = 2..7, and `hist[c][1] <= x`.
  - `last <= c`.
- No accept, but `out_ready` is high: `out_valid <= 0`. `out_data` and `out_ch` hold their last values.
- Histories of non-granted channels never change. A channel with `in_valid` low is skipped and does not consume a turn.
- An upstream producer must hold `in_valid` and data until it sees `in_ready`. The block does not require this for correctness; a dropped request is simply never accepted.
- Reset values:
  - All `hist` entries 0.
  - `out_valid` 0, `out_data` 0, `out_ch` 0.
  - `last = NCH-1`, so channel 0 has first priority after reset.

## Timing
- Latency: a sample accepted at edge N appears on `out_data` and `out_valid` after edge N, i.e. in cycle N+1.
- Throughput: one sample per cycle aggregate, provided `out_ready` is held high.
- Simultaneous drain and accept in the same cycle (`out_valid && out_ready` with a grant): the output register is overwritten and `out_valid` stays 1. There is no bubble.
- Backpressure (`out_valid && !out_ready`):
  - `in_ready` is all 0.
  - Output and all histories are frozen.
  - `last` is unchanged.
- First 7 samples of a channel after reset average against zeros.
- `reset` asserted mid-operation:
  - All state clears immediately, without waiting for a clock edge.
  - `in_ready` is 0 while `reset` is high.
  - The first edge after deassertion may accept.

## Configuration
- `MA_SCHED_STRICT_PRIO_EN`
  - Defined: fixed priority. The lowest-numbered valid channel always wins, and `last` is unused.
  - Undefined (default): round-robin as described above.
- Datapath, latency and reset behaviour are identical in both builds.

## Test plan
- Reset:
  - Assert `reset` asynchronously mid-cycle with `out_valid=1` → `out_valid`, `out_data` and `out_ch` read 0 before the next edge.
  - After release, ch0 sample 800 → `out_data=100`.
- Single-channel step:
  - Ch0 only, eight samples of 800, `out_ready=1` → `out_data` = 100, 200, …, 800 on consecutive cycles, each with `out_ch=0`.
- Negative rounding:
  - Ch1 sample −1, then seven 0s → `out_data` = −1 for 8 outputs.
  - A ninth 0 → `out_data` = 0.
- Round-robin fairness:
  - All 4 channels held valid for 8 cycles → `out_ch` sequence 0,1,2,3,0,1,2,3.
  - Each channel's history is advanced exactly twice.
- Backpressure:
  - `out_ready=0` for 3 cycles while `out_valid=1` → `out_data`/`out_ch` stable, `in_ready=0`.
  - On release, drain and next accept occur in the same cycle.
- Strict priority, with `MA_SCHED_STRICT_PRIO_EN` defined:
  - Ch0 and ch2 held valid for 4 cycles → `out_ch` = 0,0,0,0.
  - Drop ch0 → ch2 is granted the next cycle.
